ip_tx_arbiter: RTL
==================

// Module: ip_tx_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing the single IP/MAC transmit path between
//  frame generators (src0 ARP reply, src1 ICMP echo reply, src2 UDP data). Sits between the
//  generators and the IP header/MAC framing stage. Grants one source per frame, muxes its
//  byte stream and header metadata, enforces an inter-frame gap and guards against stuck sources.
// PARAMETERS
//  N_SRC       3     number of requesters (index 0..N_SRC-1); SW = clog2(N_SRC)
//  IFG_CYCLES  12    idle cycles after tx_eop before next grant; 0 = no gap
//  SOP_TIMEOUT 255   max cycles from gnt to granted src_sop before grant is revoked
//  MAX_LEN     1472  max bytes per frame; byte MAX_LEN is forced as tx_eop
// PORTS
//  sys_clk      in   1          system clock
//  sys_rst_n    in   1          asynchronous active-low reset
//  src_req      in   N_SRC      per-source frame request, held until eop or give-up
//  src_gnt      out  N_SRC      one-hot grant, registered
//  src_sop      in   N_SRC      per-source start of frame (qualified by src_vld)
//  src_eop      in   N_SRC      per-source end of frame (qualified by src_vld)
//  src_vld      in   N_SRC      per-source byte valid
//  src_dat      in   8*N_SRC    per-source byte, src i at [8i+7:8i]
//  src_ip_len   in   16*N_SRC   per-source IP total length
//  src_dst_ip   in   32*N_SRC   per-source destination IP
//  src_dst_mac  in   48*N_SRC   per-source destination MAC
//  tx_sop/eop/vld out 1 each    muxed stream framing to IP/MAC stage
//  tx_dat       out  8          muxed byte
//  tx_ip_len    out  16         latched metadata of granted source
//  tx_dst_ip    out  32         latched metadata
//  tx_dst_mac   out  48         latched metadata
//  tx_src       out  SW         index of granted source
//  busy         out  1          high in any state other than IDLE
//  err_timeout  out  1          1-cycle pulse: SOP_TIMEOUT expired
//  err_len      out  1          1-cycle pulse: MAX_LEN truncation
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0, counters 0. Async assert, sync-clean deassert.
//  States: IDLE -> WAIT_SOP -> XFER -> GAP -> IDLE.
//  IDLE: if |src_req, pick first requesting i searching rr_ptr, rr_ptr+1, ... mod N_SRC.
//   Next edge: src_gnt[i]=1, tx_src=i, tx_ip_len/dst_ip/dst_mac latched from src i
//   (held stable until next grant), rr_ptr=(i+1) mod N_SRC, -> WAIT_SOP.
//  WAIT_SOP: granted src_vld&src_sop -> XFER (that byte forwarded). src_req[i] drops -> gnt
//   cleared, -> IDLE, no error, no gap. Counter reaches SOP_TIMEOUT -> gnt cleared,
//   err_timeout pulse, -> GAP.
//  XFER: tx_* = granted src_* delayed exactly 1 cycle (registered); non-granted inputs ignored.
//   Byte counter counts granted vld bytes from 1 at sop. Repeated src_sop mid-frame passes as
//   data, tx_sop suppressed. Granted vld&eop -> tx_eop next cycle, gnt cleared same edge, -> GAP.
//   Byte count == MAX_LEN without eop -> that byte emitted with tx_eop=1, err_len pulse,
//   gnt cleared, -> GAP; remaining source bytes discarded.
//  sop&eop same cycle (1-byte frame): tx_sop=tx_eop=1 on one cycle, -> GAP.
//  GAP: count IFG_CYCLES after the cycle tx_eop is driven, then -> IDLE; IFG_CYCLES=0 -> IDLE.
//   Requests arriving in GAP wait; no grant issued in GAP.
//  tx_sop/eop/vld are 0 outside forwarded bytes; tx_dat holds last value when vld=0.
//  Reset mid-frame: stream cut immediately, no tx_eop generated; downstream discards partial.
//  Counters saturate, never wrap; rr_ptr wraps N_SRC-1 -> 0.
// TESTING
//  1 src1 req, 60-byte frame -> gnt[1] 1 cycle later; tx bytes match src, +1 cycle; tx_src=1.
//  2 src0,1,2 req together, repeated -> grant order 0,1,2,0; >=IFG_CYCLES idle between frames.
//  3 src2 granted, no sop for 255 cycles -> err_timeout pulse, gnt[2]=0, next req served after gap.
//  4 src0 streams 1500 bytes no eop -> tx_eop on byte 1472, err_len pulse, bytes 1473+ dropped.
//  5 1-byte frame (sop=eop=vld) -> single cycle tx_sop=tx_eop=tx_vld=1, metadata correct.
//  6 reset asserted mid-XFER -> all outputs 0 asynchronously, state IDLE, rr_ptr=0 after release.

Source files
------------

// File: rtl/ip_tx_arbiter_if.sv
// Bundle between the frame generators and the IP/MAC transmit stage.
// The arbiter connects through the slave modport. The generator/stage
// side (or a testbench) connects through the master modport.
interface ip_tx_arbiter_if #(
    parameter int N_SRC = 3
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Generator side, packed per source (source i in slice i).
    logic [N_SRC-1:0]    src_req;
    logic [N_SRC-1:0]    src_gnt;
    logic [N_SRC-1:0]    src_sop;
    logic [N_SRC-1:0]    src_eop;
    logic [N_SRC-1:0]    src_vld;
    logic [8*N_SRC-1:0]  src_dat;
    logic [16*N_SRC-1:0] src_ip_len;
    logic [32*N_SRC-1:0] src_dst_ip;
    logic [48*N_SRC-1:0] src_dst_mac;

    // Muxed stream and latched metadata towards the IP/MAC stage.
    logic                tx_sop;
    logic                tx_eop;
    logic                tx_vld;
    logic [7:0]          tx_dat;
    logic [15:0]         tx_ip_len;
    logic [31:0]         tx_dst_ip;
    logic [47:0]         tx_dst_mac;
    logic [SW-1:0]       tx_src;

    modport slave (
        input  src_req, src_sop, src_eop, src_vld, src_dat,
               src_ip_len, src_dst_ip, src_dst_mac,
        output src_gnt, tx_sop, tx_eop, tx_vld, tx_dat,
               tx_ip_len, tx_dst_ip, tx_dst_mac, tx_src
    );

    modport master (
        output src_req, src_sop, src_eop, src_vld, src_dat,
               src_ip_len, src_dst_ip, src_dst_mac,
        input  src_gnt, tx_sop, tx_eop, tx_vld, tx_dat,
               tx_ip_len, tx_dst_ip, tx_dst_mac, tx_src
    );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Packet-granular round-robin arbiter for the shared IP/MAC transmit path.
// The arbiter grants one source per frame. It forwards that source's bytes
// one cycle late and latches the frame metadata at grant time. After each
// frame it enforces an inter-frame gap. It revokes the grant if the source
// never starts its frame, and it truncates frames longer than MAX_LEN.
module ip_tx_arbiter #(
    parameter int N_SRC       = 3,
    parameter int IFG_CYCLES  = 12,
    parameter int SOP_TIMEOUT = 255,
    parameter int MAX_LEN     = 1472
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    ip_tx_arbiter_if.slave     bus,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_len
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_SOP, XFER, GAP} state_t;

    logic [1:0]       rst_sync;
    logic             rst_n_int;
    state_t           state, state_nxt;
    logic [SW-1:0]    rr_ptr, pick;
    logic [N_SRC-1:0] pick_onehot;
    logic             pick_vld;
    logic [15:0]      wait_cnt, gap_cnt, byte_cnt, byte_nxt;
    logic             cur_req, cur_vld, cur_sop, cur_eop;
    logic [7:0]       cur_dat;
    logic             do_grant, do_drop, do_timeout, do_fwd, fwd_first;
    logic             end_frame, trunc;
    int               idx;

    // Reset synchroniser: reset asserts at once and releases on a clock edge.
    // NOTE: only the deassertion is synchronised. Assertion stays asynchronous,
    // so the stream is cut even when the clock is not running.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    // Round-robin search starting at rr_ptr. The lowest offset that is
    // requesting wins.
    always_comb begin
        pick        = '0;
        pick_vld    = 1'b0;
        pick_onehot = '0;
        idx         = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (bus.src_req[idx]) begin
                pick     = SW'(idx);
                pick_vld = 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) pick_onehot[i] = (SW'(i) == pick);
    end

    // Signals of the currently granted source.
    always_comb begin
        cur_req = bus.src_req[bus.tx_src];
        cur_vld = bus.src_vld[bus.tx_src];
        cur_sop = bus.src_sop[bus.tx_src];
        cur_eop = bus.src_eop[bus.tx_src];
        cur_dat = bus.src_dat[int'(bus.tx_src)*8 +: 8];
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state and per-cycle action decode.
    // NOTE: every output of this block is given a default first. A path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_drop    = 1'b0;
        do_timeout = 1'b0;
        do_fwd     = 1'b0;
        fwd_first  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    do_grant  = 1'b1;
                    state_nxt = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (!cur_req) begin
                    do_drop   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt >= 16'(SOP_TIMEOUT)) begin
                    do_timeout = 1'b1;
                    state_nxt  = GAP;
                end else if (cur_vld && cur_sop) begin
                    do_fwd    = 1'b1;
                    fwd_first = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                do_fwd = cur_vld;
            end
            GAP: begin
                if (gap_cnt >= 16'(IFG_CYCLES)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        byte_nxt  = fwd_first ? 16'd1 :
                    (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
        trunc     = do_fwd && !cur_eop && (byte_nxt >= 16'(MAX_LEN));
        end_frame = do_fwd && (cur_eop || trunc);
        if (end_frame) state_nxt = GAP;
    end

    assign busy = (state != IDLE);

    // Grant, metadata latch, forwarded stream, counters and error pulses.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            bus.src_gnt    <= '0;
            bus.tx_sop     <= 1'b0;
            bus.tx_eop     <= 1'b0;
            bus.tx_vld     <= 1'b0;
            bus.tx_dat     <= '0;
            bus.tx_ip_len  <= '0;
            bus.tx_dst_ip  <= '0;
            bus.tx_dst_mac <= '0;
            bus.tx_src     <= '0;
            rr_ptr         <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            byte_cnt       <= '0;
            err_timeout    <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            bus.tx_sop  <= 1'b0;
            bus.tx_eop  <= 1'b0;
            bus.tx_vld  <= 1'b0;
            err_timeout <= do_timeout;
            err_len     <= trunc;

            if (state != WAIT_SOP)         wait_cnt <= '0;
            else if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;

            if (state != GAP)             gap_cnt <= '0;
            else if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;

            if (do_grant) begin
                bus.src_gnt    <= pick_onehot;
                bus.tx_src     <= pick;
                bus.tx_ip_len  <= bus.src_ip_len[int'(pick)*16 +: 16];
                bus.tx_dst_ip  <= bus.src_dst_ip[int'(pick)*32 +: 32];
                bus.tx_dst_mac <= bus.src_dst_mac[int'(pick)*48 +: 48];
                rr_ptr         <= (pick == SW'(N_SRC - 1)) ? '0 : pick + SW'(1);
            end

            if (do_drop || do_timeout || end_frame) bus.src_gnt <= '0;

            if (do_fwd) begin
                bus.tx_vld <= 1'b1;
                bus.tx_dat <= cur_dat;
                bus.tx_sop <= fwd_first;
                bus.tx_eop <= end_frame;
                byte_cnt   <= byte_nxt;
            end
        end
    end
endmodule
